imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Writer side of the instruction-memory interface that fetch reads. Takes a byte stream over a
//  valid/ready handshake, packs it into little-endian 32-bit words and writes them to memory.
//  Holds the core in reset until the program image is loaded.
//  Sits beside fetch and drives the memory write port: addr_i, wdata_i, write_en_i.
// PARAMETERS
//  AWIDTH          32            address width
//  DWIDTH          32            data width; must be 32 (4 bytes per word)
//  IMEM_BASE_ADDR  32'h0100_0000 byte address of word 0
//  MAX_WORDS       1024          largest accepted image, in words
// PORTS
//  clk           in   1       clock; all state updates on the rising edge
//  rst           in   1       asynchronous, active-low reset
//  start_i       in   1       one-cycle pulse; starts a load from IDLE, DONE or ERR
//  byte_valid_i  in   1       byte_data_i is valid this cycle
//  byte_data_i   in   8       stream byte
//  byte_ready_o  out  1       loader accepts a byte this cycle
//  addr_o        out  AWIDTH  memory write address
//  wdata_o       out  DWIDTH  memory write data
//  write_en_o    out  1       one-cycle memory write strobe
//  read_en_o     out  1       tied 0; the loader never reads
//  core_hold_o   out  1       1 = keep the core in reset
//  done_o        out  1       image fully written
//  error_o       out  1       header word count > MAX_WORDS
//  words_o       out  16      number of words written so far
// BEHAVIOUR
//  Reset (rst=0, asynchronous):
//   - state = IDLE, core_hold_o = 1.
//   - All other outputs = 0; byte_cnt, word_idx and len are cleared.
//   - Reset mid-load drops any partial word and does not complete the write in progress.
//  Stream format: 4-byte little-endian word count N, then N words, each 4 bytes little-endian.
//  Handshake:
//   - A byte is accepted only when byte_valid_i && byte_ready_o.
//   - byte_ready_o is 1 only in LEN and DATA.
//   - byte_valid_i is ignored in every other state.
//  Byte packing:
//   - 2-bit byte_cnt selects the lane: byte k goes to bits [8k+7:8k].
//   - byte_cnt wraps 3 -> 0 on the 4th accepted byte.
//  States:
//   - IDLE: start_i -> LEN.
//   - LEN: 4th byte accepted -> latch N.
//     - N == 0 -> DONE.
//     - N > MAX_WORDS -> ERR.
//     - otherwise -> DATA.
//   - DATA: 4th byte accepted -> WRITE.
//   - WRITE: one cycle, byte_ready_o = 0.
//     - Drives write_en_o = 1, addr_o = IMEM_BASE_ADDR + 4*word_idx, wdata_o = packed word.
//     - Then word_idx++ and words_o++.
//     - word_idx+1 == N -> DONE; else -> DATA.
//   - DONE: done_o = 1, core_hold_o = 0.
//   - ERR: error_o = 1, core_hold_o = 1.
//  Restart:
//   - start_i in DONE or ERR -> LEN; clears done_o, error_o, words_o, word_idx; sets core_hold_o = 1.
//   - start_i in LEN, DATA or WRITE is ignored.
//  Latency:
//   - Last byte of a word accepted in cycle t -> write_en_o high in t+1.
//   - Last word's write in cycle t -> done_o and core_hold_o = 0 in t+1.
//  Idle values: outside WRITE, write_en_o = 0; addr_o and wdata_o hold their last values.
//  Width: addr_o is computed modulo 2^AWIDTH; word_idx is 16 bits wide, so MAX_WORDS <= 65535.
// STRUCTURE
//  - constants.svh (shared package) holds: loader_state_e {IDLE, LEN, DATA, WRITE, DONE, ERR},
//    IMEM_BASE_ADDR, LOADER_MAX_WORDS.
//  - Sub-module byte_packer: byte_cnt, 32-bit packing register, word_valid pulse.
//    It serves both LEN and DATA.
//  - Parent module holds the FSM, word_idx/len counters and the memory-port drive.
// TESTING
//  1. Reset, start_i, bytes 01 00 00 00 13 05 a0 00
//     -> one write: addr 0x0100_0000, data 0x00a0_0513;
//     -> done_o = 1 next cycle; core_hold_o = 0; words_o = 1.
//  2. N = 3 with byte_valid_i gaps between bytes
//     -> writes to 0x0100_0000, 0x0100_0004, 0x0100_0008;
//     -> no write on a cycle where no byte was accepted.
//  3. Header N = 0 -> DONE with no write_en_o pulse.
//     Header N = 1025 (MAX_WORDS = 1024) -> error_o = 1, core_hold_o = 1, byte_ready_o = 0.
//  4. Pull rst low after 2 data bytes of word 1
//     -> IDLE immediately, no write;
//     -> then start_i plus a full stream loads correctly from word 0.
//  5. start_i pulsed during DATA -> ignored, words_o unaffected.
//     start_i in DONE -> done_o = 0, core_hold_o = 1, new load starts.
//  6. byte_valid_i held high during WRITE -> no byte consumed; byte_cnt unchanged.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
//   loader_state_e    : loader FSM encoding
//   IMEM_BASE_ADDR    : byte address of instruction word 0
//   LOADER_MAX_WORDS  : largest program image accepted, in 32-bit words
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN   = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } loader_state_e;

  localparam logic [31:0] IMEM_BASE_ADDR   = 32'h0100_0000;
  localparam int unsigned LOADER_MAX_WORDS = 1024;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs an accepted byte stream into little-endian 32-bit words.
// Used for both the length header and the data words.
//   clk, rst      : clock, asynchronous active-low reset
//   clear_i       : drop any partial word and restart at lane 0
//   byte_fire_i   : a byte is accepted this cycle
//   byte_data_i   : the accepted byte
//   word_o        : packed word including this cycle's byte (valid with word_valid_o)
//   word_valid_o  : this cycle's byte completes a word (4th accepted byte)
//   byte_cnt_o    : lane the next accepted byte will land in
module imem_loader_byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear_i,
  input  logic        byte_fire_i,
  input  logic [7:0]  byte_data_i,
  output logic [31:0] word_o,
  output logic        word_valid_o,
  output logic [1:0]  byte_cnt_o
);

  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] pack_q, pack_d;

  always_comb begin
    pack_d     = pack_q;
    byte_cnt_d = byte_cnt_q;
    if (clear_i) begin
      pack_d     = '0;
      byte_cnt_d = '0;
    end else if (byte_fire_i) begin
      pack_d[8*byte_cnt_q +: 8] = byte_data_i;
      byte_cnt_d                = byte_cnt_q + 2'd1;  // wraps 3 -> 0
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pack_q     <= '0;
      byte_cnt_q <= '0;
    end else begin
      pack_q     <= pack_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

  // The completed word is offered in the same cycle as its last byte so the
  // parent can register it at that edge, giving a write one cycle later.
  assign word_o       = pack_d;
  assign word_valid_o = byte_fire_i && !clear_i && (byte_cnt_q == 2'd3);
  assign byte_cnt_o   = byte_cnt_q;

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: receives a byte stream (4-byte LE word count N,
// then N LE words), writes the words to instruction memory and holds the core
// in reset until the image is in place.
//   clk, rst       : clock, asynchronous active-low reset
//   start_i        : pulse; starts a load from IDLE, DONE or ERR
//   byte_valid_i   : stream byte valid
//   byte_data_i    : stream byte
//   byte_ready_o   : loader can take a byte (LEN and DATA only)
//   addr_o         : memory write byte address
//   wdata_o        : memory write data
//   write_en_o     : one-cycle write strobe
//   read_en_o      : always 0
//   core_hold_o    : 1 keeps the core in reset
//   done_o         : image fully written
//   error_o        : header word count exceeded MAX_WORDS
//   words_o        : words written so far
//   state_o        : current FSM state (debug)
// Handshake: a byte transfers on a rising edge where byte_valid_i and
// byte_ready_o are both 1; byte_ready_o depends only on state, never on
// byte_valid_i, and byte_valid_i is ignored whenever byte_ready_o is 0.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned AWIDTH         = 32,
  parameter int unsigned DWIDTH         = 32,
  parameter logic [AWIDTH-1:0] IMEM_BASE_ADDR = AWIDTH'(imem_loader_pkg::IMEM_BASE_ADDR),
  parameter int unsigned MAX_WORDS      = imem_loader_pkg::LOADER_MAX_WORDS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_data_i,
  output logic              byte_ready_o,
  output logic [AWIDTH-1:0] addr_o,
  output logic [DWIDTH-1:0] wdata_o,
  output logic              write_en_o,
  output logic              read_en_o,
  output logic              core_hold_o,
  output logic              done_o,
  output logic              error_o,
  output logic [15:0]       words_o,
  output loader_state_e     state_o
);

  loader_state_e     state_q;
  logic [31:0]       len_q;
  logic [15:0]       word_idx_q;
  logic [15:0]       words_q;
  logic [AWIDTH-1:0] addr_q;
  logic [DWIDTH-1:0] wdata_q;
  logic              write_en_q;
  logic              hold_q;
  logic              done_q;
  logic              error_q;

  logic              byte_fire;
  logic              start_ok;
  logic [31:0]       word;
  logic              word_valid;
  logic [1:0]        byte_cnt;

  assign byte_ready_o = (state_q == LEN) || (state_q == DATA);
  assign byte_fire    = byte_valid_i && byte_ready_o;
  assign start_ok     = start_i && ((state_q == IDLE) || (state_q == DONE) || (state_q == ERR));

  imem_loader_byte_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (start_ok),
    .byte_fire_i  (byte_fire),
    .byte_data_i  (byte_data_i),
    .word_o       (word),
    .word_valid_o (word_valid),
    .byte_cnt_o   (byte_cnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      len_q      <= '0;
      word_idx_q <= '0;
      words_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      write_en_q <= 1'b0;
      hold_q     <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      write_en_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) state_q <= LEN;
        end
        LEN: begin
          if (word_valid) begin
            len_q <= word;
            if (word == 32'd0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              hold_q  <= 1'b0;
            end else if (word > 32'(MAX_WORDS)) begin
              state_q <= ERR;
              error_q <= 1'b1;
            end else begin
              state_q <= DATA;
            end
          end
        end
        DATA: begin
          if (word_valid) begin
            state_q    <= WRITE;
            write_en_q <= 1'b1;
            addr_q     <= IMEM_BASE_ADDR + (AWIDTH'(word_idx_q) << 2);
            wdata_q    <= DWIDTH'(word);
          end
        end
        WRITE: begin
          word_idx_q <= word_idx_q + 16'd1;
          words_q    <= words_q + 16'd1;
          if ((32'(word_idx_q) + 32'd1) == len_q) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            hold_q  <= 1'b0;
          end else begin
            state_q <= DATA;
          end
        end
        DONE, ERR: begin
          if (start_i) begin
            state_q    <= LEN;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            words_q    <= '0;
            word_idx_q <= '0;
            hold_q     <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign addr_o      = addr_q;
  assign wdata_o     = wdata_q;
  assign write_en_o  = write_en_q;
  assign read_en_o   = 1'b0;
  assign core_hold_o = hold_q;
  assign done_o      = done_q;
  assign error_o     = error_q;
  assign words_o     = words_q;
  assign state_o     = state_q;

  // Lane position is only observed for debug.
  logic unused_ok;
  assign unused_ok = ^byte_cnt;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  localparam logic [31:0] BASE = 32'h0100_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        byte_valid_i;
  logic [7:0]  byte_data_i;
  logic        byte_ready_o;
  logic [31:0] addr_o;
  logic [31:0] wdata_o;
  logic        write_en_o;
  logic        read_en_o;
  logic        core_hold_o;
  logic        done_o;
  logic        error_o;
  logic [15:0] words_o;
  imem_loader_pkg::loader_state_e state_o;

  int checks = 0;
  int passed = 0;
  logic [63:0] exp_q[$];

  imem_loader dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .byte_valid_i (byte_valid_i),
    .byte_data_i  (byte_data_i),
    .byte_ready_o (byte_ready_o),
    .addr_o       (addr_o),
    .wdata_o      (wdata_o),
    .write_en_o   (write_en_o),
    .read_en_o    (read_en_o),
    .core_hold_o  (core_hold_o),
    .done_o       (done_o),
    .error_o      (error_o),
    .words_o      (words_o),
    .state_o      (state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin : monitor
    logic [63:0] e;
    if (rst === 1'b1 && write_en_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h with no write expected", addr_o, wdata_o);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", addr_o, e[63:32]);
        check("write_data", wdata_o, e[31:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  // Presents one byte and holds it until accepted (bounded wait).
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) step();
    byte_valid_i = 1'b1;
    byte_data_i  = b;
    n = 0;
    @(negedge clk);
    while (!byte_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!byte_ready_o) begin
      checks++;
      $display("FAIL byte_accept_timeout: byte_ready_o stayed 0 for byte 0x%0h", b);
    end
    @(posedge clk); #1;
    byte_valid_i = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    send_byte(w[7:0],   gap);
    send_byte(w[15:8],  gap);
    send_byte(w[23:16], gap);
    send_byte(w[31:24], gap);
  endtask

  // Data word: push the expected write, send it, and confirm the strobe is
  // up in the cycle after the last byte was accepted.
  task automatic load_word(input int idx, input logic [31:0] w, input int gap);
    exp_q.push_back({BASE + 32'(idx) * 32'd4, w});
    send_word(w, gap);
    check("write_latency", 32'(write_en_o), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst          = 1'b0;
    start_i      = 1'b0;
    byte_valid_i = 1'b0;
    byte_data_i  = 8'h00;
    repeat (3) step();

    // Reset state
    check("rst_core_hold",  32'(core_hold_o),  32'd1);
    check("rst_done",       32'(done_o),       32'd0);
    check("rst_error",      32'(error_o),      32'd0);
    check("rst_write_en",   32'(write_en_o),   32'd0);
    check("rst_byte_ready", 32'(byte_ready_o), 32'd0);
    check("rst_words",      32'(words_o),      32'd0);
    check("rst_read_en",    32'(read_en_o),    32'd0);
    rst = 1'b1;
    step();

    // 1: single-word image
    pulse_start();
    send_word(32'd1, 0);
    load_word(0, 32'h00a0_0513, 0);
    step();
    check("t1_done",  32'(done_o),      32'd1);
    check("t1_hold",  32'(core_hold_o), 32'd0);
    check("t1_words", 32'(words_o),     32'd1);

    // 5b/2: restart from DONE, then three words with gaps between bytes
    pulse_start();
    check("restart_done",  32'(done_o),      32'd0);
    check("restart_hold",  32'(core_hold_o), 32'd1);
    check("restart_words", 32'(words_o),     32'd0);
    send_word(32'd3, 2);
    load_word(0, 32'h1122_3344, 2);
    load_word(1, 32'hdead_beef, 3);
    load_word(2, 32'h0000_0001, 1);
    step();
    check("t2_done",  32'(done_o),  32'd1);
    check("t2_words", 32'(words_o), 32'd3);

    // 3: empty image, then oversized header
    pulse_start();
    send_word(32'd0, 0);
    check("t3_zero_done",  32'(done_o),      32'd1);
    check("t3_zero_hold",  32'(core_hold_o), 32'd0);
    check("t3_zero_words", 32'(words_o),     32'd0);
    step();
    pulse_start();
    send_word(32'd1025, 0);
    check("t3_err_error", 32'(error_o),      32'd1);
    check("t3_err_hold",  32'(core_hold_o),  32'd1);
    check("t3_err_ready", 32'(byte_ready_o), 32'd0);
    check("t3_err_done",  32'(done_o),       32'd0);

    // 4: reset in the middle of word 1, then a clean reload
    pulse_start();
    check("t4_error_cleared", 32'(error_o), 32'd0);
    send_word(32'd2, 0);
    load_word(0, 32'hcafe_f00d, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    rst = 1'b0;
    #1;
    check("t4_state_idle", 32'(state_o),      32'(imem_loader_pkg::IDLE));
    check("t4_ready",      32'(byte_ready_o), 32'd0);
    check("t4_hold",       32'(core_hold_o),  32'd1);
    check("t4_words",      32'(words_o),      32'd0);
    check("t4_write_en",   32'(write_en_o),   32'd0);
    repeat (2) step();
    rst = 1'b1;
    step();
    pulse_start();
    send_word(32'd1, 0);
    load_word(0, 32'h0123_4567, 0);
    step();
    check("t4_done",  32'(done_o),  32'd1);
    check("t4_words", 32'(words_o), 32'd1);

    // 5a: start_i during DATA is ignored
    pulse_start();
    send_word(32'd2, 0);
    load_word(0, 32'h89ab_cdef, 0);
    exp_q.push_back({BASE + 32'd4, 32'h1234_5678});
    send_byte(8'h78, 0);
    send_byte(8'h56, 0);
    pulse_start();
    check("t5_words_mid", 32'(words_o),     32'd1);
    check("t5_hold_mid",  32'(core_hold_o), 32'd1);
    send_byte(8'h34, 0);
    send_byte(8'h12, 0);
    check("t5_write_latency", 32'(write_en_o), 32'd1);
    step();
    check("t5_done",  32'(done_o),  32'd1);
    check("t5_words", 32'(words_o), 32'd2);

    // 6: valid held high with a junk byte across the WRITE cycle
    pulse_start();
    send_word(32'd2, 0);
    load_word(0, 32'haaaa_5555, 0);
    byte_valid_i = 1'b1;
    byte_data_i  = 8'hee;
    check("t6_ready_in_write", 32'(byte_ready_o), 32'd0);
    step();
    byte_valid_i = 1'b0;
    load_word(1, 32'h0403_0201, 0);
    step();
    check("t6_done",  32'(done_o),  32'd1);
    check("t6_words", 32'(words_o), 32'd2);

    repeat (3) step();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
